branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Parametrised successor of the EX-stage branch adder.
- Computes the branch target EX_BranchPC = EX_PCadd4 + (EX_Immediate32 << IMM_SHIFT).
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, looked up by IF and trained by EX.
- Flags mispredictions and supplies the redirect PC. Sits between IF (PC mux) and EX (branch resolve).

Parameters:
- WIDTH, 32, address/data width in bits.
- DEPTH, 16, BTB entries; power of 2, at least 2. IDX = log2(DEPTH).
- IMM_SHIFT, 2, left shift applied to the immediate before the add.
- CTR_INIT, 2'b01, counter value written on reset (weakly not-taken).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-low reset.
- IF_PC  in  WIDTH  fetch PC to look up.
- IF_Hit  out  1  BTB valid entry with matching tag.
- IF_PredTaken  out  1  predicted taken (IF_Hit && ctr[1]).
- IF_PredTarget  out  WIDTH  next fetch PC: stored target if IF_PredTaken, else IF_PC+4.
- EX_Valid  in  1  EX holds a real instruction (not a bubble).
- EX_IsBranch  in  1  EX instruction is a conditional branch.
- EX_Taken  in  1  resolved branch outcome.
- EX_PC  in  WIDTH  PC of the EX instruction.
- EX_PCadd4  in  WIDTH  EX_PC+4.
- EX_Immediate32  in  WIDTH  sign-extended immediate.
- EX_PredTaken  in  1  IF_PredTaken carried down the pipeline.
- EX_PredTarget  in  WIDTH  IF_PredTarget carried down the pipeline.
- EX_BranchPC  out  WIDTH  computed branch target.
- EX_Mispredict  out  1  flush request.
- EX_RedirectPC  out  WIDTH  correct next PC when EX_Mispredict is 1.
- MispredictCount  out  WIDTH  registered count of mispredictions.

Behaviour:
- Arithmetic: EX_BranchPC is combinational, modulo 2^WIDTH. The immediate is shifted left by IMM_SHIFT with low bits zero-filled; upper bits are dropped, no saturation.
- Indexing: index = PC[IDX+1:2]; tag = PC[WIDTH-1:IDX+2]. PC[1:0] is ignored.
- Entry contents: valid, tag, target (WIDTH bits), ctr (2 bits).
- Lookup: combinational read of registered state; zero cycles of latency.
- Training: occurs at posedge when EX_Valid && EX_IsBranch && Reset == 1.
  - Hit: ctr increments (saturates at 3) if taken, decrements (saturates at 0) if not taken. Target is overwritten with EX_BranchPC only when taken.
  - Miss and taken: allocate (replace): valid=1, tag, target=EX_BranchPC, ctr=2'b10.
  - Miss and not taken: no change.
- Mispredict (combinational):
  - EX_Mispredict = EX_Valid && EX_IsBranch && ((EX_Taken != EX_PredTaken) || (EX_Taken && EX_PredTarget != EX_BranchPC)).
  - EX_RedirectPC = EX_Taken ? EX_BranchPC : EX_PCadd4.
  - Both are 0 when EX_Valid=0 or EX_IsBranch=0.
- MispredictCount: increments by 1 at posedge when EX_Mispredict=1; wraps from all-ones to 0.
- Reset (Reset=0 at posedge):
  - All valid bits cleared, all ctr set to CTR_INIT, MispredictCount cleared to 0.
  - Training is suppressed that cycle.
  - After reset: IF_Hit=0, IF_PredTaken=0, IF_PredTarget=IF_PC+4.
  - Reset asserted mid-training wins; no entry is written.
- Same-index read/write in one cycle (without bypass): IF sees the pre-update contents; the update is visible the next cycle.
- Aliasing: two PCs with the same index evict each other; the newest taken branch wins.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- When defined: if training writes the same index that IF reads this cycle, IF_Hit/IF_PredTaken/IF_PredTarget reflect the post-update entry combinationally. This applies only when the tag of IF_PC matches the tag being written.
- When undefined: old contents are returned, as in Behaviour. No other difference.

Test Plan:
- Adder: EX_PCadd4=0x32, imm=-2 -> EX_BranchPC=0x2A; EX_PCadd4=0x84, imm=-2 -> 0x7C; EX_PCadd4=0xFFFFFFFC, imm=2 -> 0x00000004 (wrap).
- Cold miss: after reset, IF_PC=0x40 -> IF_Hit=0, IF_PredTarget=0x44.
  - EX branch at 0x40, taken, EX_PCadd4=0x44, imm=4 -> EX_Mispredict=1, EX_RedirectPC=0x54, MispredictCount=1.
  - Next cycle IF_PC=0x40 -> IF_Hit=1, IF_PredTaken=1, IF_PredTarget=0x54.
- Saturation: train PC 0x40 with taken x3 -> ctr=3.
  - One not-taken -> ctr=2, still predicted taken.
  - Second not-taken -> ctr=1, predicted not taken, IF_PredTarget=0x44.
- Alias: DEPTH=16, train 0x40 taken, then 0x80 taken -> lookup 0x40 misses, lookup 0x80 hits.
- Same-cycle read/write at 0x40 (entry empty, training taken): IF_Hit=0 without BTB_BYPASS_EN, IF_Hit=1 with it.
- Reset mid-stream: Reset=0 while EX_Mispredict=1 -> no entry written, MispredictCount=0, all lookups miss afterwards.

Source files
------------

// File: rtl/branch_target_predictor.sv
// EX-stage branch adder plus a direct-mapped BTB with 2-bit counters, mispredict flag and counter.
// Optional same-cycle write-to-read bypass enabled by defining BTB_BYPASS_EN.
module branch_target_predictor #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IMM_SHIFT = 2,
  parameter logic [1:0]  CTR_INIT  = 2'b01
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] IF_PC,
  output logic             IF_Hit,
  output logic             IF_PredTaken,
  output logic [WIDTH-1:0] IF_PredTarget,
  input  logic             EX_Valid,
  input  logic             EX_IsBranch,
  input  logic             EX_Taken,
  input  logic [WIDTH-1:0] EX_PC,
  input  logic [WIDTH-1:0] EX_PCadd4,
  input  logic [WIDTH-1:0] EX_Immediate32,
  input  logic             EX_PredTaken,
  input  logic [WIDTH-1:0] EX_PredTarget,
  output logic [WIDTH-1:0] EX_BranchPC,
  output logic             EX_Mispredict,
  output logic [WIDTH-1:0] EX_RedirectPC,
  output logic [WIDTH-1:0] MispredictCount
);

  localparam int unsigned IDX  = $clog2(DEPTH);
  localparam int unsigned TAGW = WIDTH - IDX - 2;

  typedef struct packed {
    logic             valid;
    logic [TAGW-1:0]  tag;
    logic [WIDTH-1:0] target;
    logic [1:0]       ctr;
  } btb_entry_t;

  localparam btb_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT};

  btb_entry_t [DEPTH-1:0] btb_q, btb_d;
  logic [WIDTH-1:0]       count_q, count_d;

  logic [IDX-1:0]  ex_idx, rd_idx;
  logic [TAGW-1:0] ex_tag, rd_tag;
  logic            is_branch;
  logic            ex_hit;
  logic            wr_en;
  btb_entry_t      wr_entry;
  btb_entry_t      rd_entry;
  logic            unused_pc_lsbs;

  assign unused_pc_lsbs = ^{IF_PC[1:0], EX_PC[1:0]};

  assign ex_idx = EX_PC[IDX+1:2];
  assign ex_tag = EX_PC[WIDTH-1:IDX+2];
  assign rd_idx = IF_PC[IDX+1:2];
  assign rd_tag = IF_PC[WIDTH-1:IDX+2];

  // Branch target adder, modulo 2^WIDTH.
  assign EX_BranchPC = EX_PCadd4 + WIDTH'(EX_Immediate32 << IMM_SHIFT);

  assign is_branch = EX_Valid && EX_IsBranch;

  always_comb begin
    EX_Mispredict = 1'b0;
    EX_RedirectPC = '0;
    if (is_branch) begin
      EX_Mispredict = (EX_Taken != EX_PredTaken) ||
                      (EX_Taken && (EX_PredTarget != EX_BranchPC));
      EX_RedirectPC = EX_Taken ? EX_BranchPC : EX_PCadd4;
    end
  end

  // Training: build the post-update entry for the EX index.
  always_comb begin
    ex_hit   = btb_q[ex_idx].valid && (btb_q[ex_idx].tag == ex_tag);
    wr_en    = 1'b0;
    wr_entry = btb_q[ex_idx];
    if (is_branch && Reset) begin
      if (ex_hit) begin
        wr_en = 1'b1;
        if (EX_Taken) begin
          wr_entry.target = EX_BranchPC;
          if (wr_entry.ctr != 2'b11) wr_entry.ctr = wr_entry.ctr + 2'b01;
        end else if (wr_entry.ctr != 2'b00) begin
          wr_entry.ctr = wr_entry.ctr - 2'b01;
        end
      end else if (EX_Taken) begin
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = ex_tag;
        wr_entry.target = EX_BranchPC;
        wr_entry.ctr    = 2'b10;
      end
    end
  end

  always_comb begin
    btb_d = btb_q;
    if (wr_en) btb_d[ex_idx] = wr_entry;
    count_d = count_q + WIDTH'(EX_Mispredict);
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      btb_q   <= {DEPTH{RESET_ENTRY}};
      count_q <= '0;
    end else begin
      btb_q   <= btb_d;
      count_q <= count_d;
    end
  end

  assign MispredictCount = count_q;

  // Lookup: zero-latency read of registered state, optionally bypassing the in-flight write.
  always_comb begin
    rd_entry = btb_q[rd_idx];
`ifdef BTB_BYPASS_EN
    if (wr_en && (ex_idx == rd_idx) && (wr_entry.tag == rd_tag)) rd_entry = wr_entry;
`endif
    IF_Hit        = rd_entry.valid && (rd_entry.tag == rd_tag);
    IF_PredTaken  = IF_Hit && rd_entry.ctr[1];
    IF_PredTarget = IF_PredTaken ? rd_entry.target : IF_PC + WIDTH'(4);
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor (default parameters).
module tb_branch_target_predictor;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] IF_PC = '0;
  logic        IF_Hit, IF_PredTaken;
  logic [31:0] IF_PredTarget;
  logic        EX_Valid = 1'b0, EX_IsBranch = 1'b0, EX_Taken = 1'b0, EX_PredTaken = 1'b0;
  logic [31:0] EX_PC = '0, EX_PCadd4 = '0, EX_Immediate32 = '0, EX_PredTarget = '0;
  logic [31:0] EX_BranchPC, EX_RedirectPC, MispredictCount;
  logic        EX_Mispredict;

  int checks = 0;
  int failures = 0;

  branch_target_predictor dut (
    .CLK(CLK), .Reset(Reset), .IF_PC(IF_PC), .IF_Hit(IF_Hit), .IF_PredTaken(IF_PredTaken),
    .IF_PredTarget(IF_PredTarget), .EX_Valid(EX_Valid), .EX_IsBranch(EX_IsBranch),
    .EX_Taken(EX_Taken), .EX_PC(EX_PC), .EX_PCadd4(EX_PCadd4), .EX_Immediate32(EX_Immediate32),
    .EX_PredTaken(EX_PredTaken), .EX_PredTarget(EX_PredTarget), .EX_BranchPC(EX_BranchPC),
    .EX_Mispredict(EX_Mispredict), .EX_RedirectPC(EX_RedirectPC), .MispredictCount(MispredictCount)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic ex_idle();
    EX_Valid = 1'b0; EX_IsBranch = 1'b0; EX_Taken = 1'b0; EX_PC = '0; EX_PCadd4 = '0;
    EX_Immediate32 = '0; EX_PredTaken = 1'b0; EX_PredTarget = '0;
  endtask

  task automatic ex_branch(input logic [31:0] pc, input logic taken, input logic [31:0] imm,
                           input logic pt, input logic [31:0] ptgt);
    EX_Valid = 1'b1; EX_IsBranch = 1'b1; EX_Taken = taken; EX_PC = pc; EX_PCadd4 = pc + 32'd4;
    EX_Immediate32 = imm; EX_PredTaken = pt; EX_PredTarget = ptgt;
  endtask

  task automatic do_reset();
    ex_idle();
    Reset = 1'b0;
    step();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    IF_PC = 32'h40; #1;
    checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%0h exp=0", IF_Hit); end
    checks++; if (IF_PredTaken !== 1'b0) begin failures++; $display("FAIL reset_predtaken got=%0h exp=0", IF_PredTaken); end
    checks++; if (IF_PredTarget !== 32'h44) begin failures++; $display("FAIL reset_target got=%0h exp=44", IF_PredTarget); end
    checks++; if (MispredictCount !== 32'd0) begin failures++; $display("FAIL reset_count got=%0h exp=0", MispredictCount); end
    checks++; if (EX_Mispredict !== 1'b0) begin failures++; $display("FAIL reset_mispredict got=%0h exp=0", EX_Mispredict); end
  endtask

  task automatic test_adder();
    ex_idle();
    EX_PCadd4 = 32'h32; EX_Immediate32 = 32'hFFFF_FFFE; #1;
    checks++; if (EX_BranchPC !== 32'h2A) begin failures++; $display("FAIL adder_neg1 got=%0h exp=2a", EX_BranchPC); end
    EX_PCadd4 = 32'h84; #1;
    checks++; if (EX_BranchPC !== 32'h7C) begin failures++; $display("FAIL adder_neg2 got=%0h exp=7c", EX_BranchPC); end
    EX_PCadd4 = 32'hFFFF_FFFC; EX_Immediate32 = 32'h2; #1;
    checks++; if (EX_BranchPC !== 32'h4) begin failures++; $display("FAIL adder_wrap got=%0h exp=4", EX_BranchPC); end
    // Gating: a taken branch that is a bubble or not a branch flags nothing.
    EX_Valid = 1'b0; EX_IsBranch = 1'b1; EX_Taken = 1'b1; #1;
    checks++; if (EX_Mispredict !== 1'b0) begin failures++; $display("FAIL gate_valid got=%0h exp=0", EX_Mispredict); end
    EX_Valid = 1'b1; EX_IsBranch = 1'b0; #1;
    checks++; if (EX_RedirectPC !== 32'h0) begin failures++; $display("FAIL gate_redirect got=%0h exp=0", EX_RedirectPC); end
    ex_idle();
  endtask

  task automatic test_cold_miss();
    do_reset();
    IF_PC = 32'h40; #1;
    checks++; if (IF_PredTarget !== 32'h44) begin failures++; $display("FAIL cold_target got=%0h exp=44", IF_PredTarget); end
    ex_branch(32'h40, 1'b1, 32'h4, 1'b0, 32'h44); #1;
    checks++; if (EX_Mispredict !== 1'b1) begin failures++; $display("FAIL cold_mispredict got=%0h exp=1", EX_Mispredict); end
    checks++; if (EX_RedirectPC !== 32'h54) begin failures++; $display("FAIL cold_redirect got=%0h exp=54", EX_RedirectPC); end
    step(); ex_idle(); #1;
    checks++; if (MispredictCount !== 32'd1) begin failures++; $display("FAIL cold_count got=%0h exp=1", MispredictCount); end
    checks++; if ({IF_Hit, IF_PredTaken} !== 2'b11) begin failures++; $display("FAIL cold_hit got=%0b exp=11", {IF_Hit, IF_PredTaken}); end
    checks++; if (IF_PredTarget !== 32'h54) begin failures++; $display("FAIL cold_trained got=%0h exp=54", IF_PredTarget); end
  endtask

  task automatic test_not_taken_miss();
    do_reset();
    IF_PC = 32'h40;
    ex_branch(32'h40, 1'b0, 32'h4, 1'b0, 32'h44); #1;
    checks++; if (EX_Mispredict !== 1'b0) begin failures++; $display("FAIL nt_mispredict got=%0h exp=0", EX_Mispredict); end
    checks++; if (EX_RedirectPC !== 32'h44) begin failures++; $display("FAIL nt_redirect got=%0h exp=44", EX_RedirectPC); end
    step(); ex_idle(); #1;
    checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL nt_no_alloc got=%0h exp=0", IF_Hit); end
  endtask

  task automatic test_saturation();
    do_reset();
    IF_PC = 32'h40;
    ex_branch(32'h40, 1'b1, 32'h4, 1'b0, 32'h44); step();
    ex_branch(32'h40, 1'b1, 32'h4, 1'b1, 32'h54); #1;
    checks++; if (EX_Mispredict !== 1'b0) begin failures++; $display("FAIL sat_correct got=%0h exp=0", EX_Mispredict); end
    step(); step();
    ex_branch(32'h40, 1'b0, 32'h4, 1'b1, 32'h54); #1;
    checks++; if (EX_RedirectPC !== 32'h44) begin failures++; $display("FAIL sat_nt_redirect got=%0h exp=44", EX_RedirectPC); end
    step(); #1;
    // ctr 3 -> 2: still taken
    checks++; if ({IF_Hit, IF_PredTaken} !== 2'b11) begin failures++; $display("FAIL sat_ctr2 got=%0b exp=11", {IF_Hit, IF_PredTaken}); end
    step(); #1;
    // ctr 2 -> 1: not taken
    checks++; if ({IF_Hit, IF_PredTaken} !== 2'b10) begin failures++; $display("FAIL sat_ctr1 got=%0b exp=10", {IF_Hit, IF_PredTaken}); end
    checks++; if (IF_PredTarget !== 32'h44) begin failures++; $display("FAIL sat_ctr1_target got=%0h exp=44", IF_PredTarget); end
    checks++; if (MispredictCount !== 32'd3) begin failures++; $display("FAIL sat_count got=%0h exp=3", MispredictCount); end
    ex_branch(32'h40, 1'b0, 32'h4, 1'b0, 32'h44); step(); step();
    ex_branch(32'h40, 1'b1, 32'h4, 1'b0, 32'h44); step(); ex_idle(); #1;
    // ctr floors at 0, so one taken only reaches 1
    checks++; if ({IF_Hit, IF_PredTaken} !== 2'b10) begin failures++; $display("FAIL sat_floor got=%0b exp=10", {IF_Hit, IF_PredTaken}); end
    checks++; if (MispredictCount !== 32'd4) begin failures++; $display("FAIL sat_count2 got=%0h exp=4", MispredictCount); end
  endtask

  task automatic test_target_update();
    do_reset();
    IF_PC = 32'h40;
    ex_branch(32'h40, 1'b1, 32'h4, 1'b0, 32'h44); step();
    ex_branch(32'h40, 1'b1, 32'h8, 1'b1, 32'h54); #1;
    checks++; if (EX_Mispredict !== 1'b1) begin failures++; $display("FAIL tgt_mispredict got=%0h exp=1", EX_Mispredict); end
    checks++; if (EX_RedirectPC !== 32'h64) begin failures++; $display("FAIL tgt_redirect got=%0h exp=64", EX_RedirectPC); end
    step(); ex_idle(); #1;
    checks++; if (IF_PredTarget !== 32'h64) begin failures++; $display("FAIL tgt_update got=%0h exp=64", IF_PredTarget); end
  endtask

  task automatic test_alias();
    do_reset();
    ex_branch(32'h40, 1'b1, 32'h4, 1'b0, 32'h44); step();
    ex_branch(32'h80, 1'b1, 32'h4, 1'b0, 32'h84); step(); ex_idle();
    IF_PC = 32'h40; #1;
    checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL alias_evicted got=%0h exp=0", IF_Hit); end
    IF_PC = 32'h80; #1;
    checks++; if (IF_Hit !== 1'b1) begin failures++; $display("FAIL alias_hit got=%0h exp=1", IF_Hit); end
    checks++; if (IF_PredTarget !== 32'h94) begin failures++; $display("FAIL alias_target got=%0h exp=94", IF_PredTarget); end
    IF_PC = 32'h82; #1;
    checks++; if (IF_PredTarget !== 32'h94) begin failures++; $display("FAIL alias_lsbs got=%0h exp=94", IF_PredTarget); end
    IF_PC = 32'h44; #1;
    checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL alias_other_idx got=%0h exp=0", IF_Hit); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    ex_branch(32'h40, 1'b1, 32'h4, 1'b0, 32'h44);
    IF_PC = 32'h80; #1;
    checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL same_tag_mismatch got=%0h exp=0", IF_Hit); end
    IF_PC = 32'h40; #1;
`ifdef BTB_BYPASS_EN
    checks++; if (IF_Hit !== 1'b1) begin failures++; $display("FAIL same_bypass_hit got=%0h exp=1", IF_Hit); end
    checks++; if (IF_PredTarget !== 32'h54) begin failures++; $display("FAIL same_bypass_target got=%0h exp=54", IF_PredTarget); end
`else
    checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL same_old_hit got=%0h exp=0", IF_Hit); end
    checks++; if (IF_PredTarget !== 32'h44) begin failures++; $display("FAIL same_old_target got=%0h exp=44", IF_PredTarget); end
`endif
    step(); ex_idle(); #1;
    checks++; if (IF_Hit !== 1'b1) begin failures++; $display("FAIL same_next_hit got=%0h exp=1", IF_Hit); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ex_branch(32'h80, 1'b1, 32'h4, 1'b0, 32'h84); step();
    ex_branch(32'h44, 1'b1, 32'h4, 1'b0, 32'h48); #1;
    checks++; if (EX_Mispredict !== 1'b1) begin failures++; $display("FAIL mid_mispredict got=%0h exp=1", EX_Mispredict); end
    Reset = 1'b0;
    IF_PC = 32'h44; #1;
    checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL mid_no_bypass got=%0h exp=0", IF_Hit); end
    step(); Reset = 1'b1; ex_idle(); #1;
    checks++; if (MispredictCount !== 32'd0) begin failures++; $display("FAIL mid_count got=%0h exp=0", MispredictCount); end
    checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL mid_no_write got=%0h exp=0", IF_Hit); end
    IF_PC = 32'h80; #1;
    checks++; if (IF_Hit !== 1'b0) begin failures++; $display("FAIL mid_cleared got=%0h exp=0", IF_Hit); end
  endtask

  initial begin
    test_reset();
    test_adder();
    test_cold_miss();
    test_not_taken_miss();
    test_saturation();
    test_target_update();
    test_alias();
    test_same_cycle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
